// File: rtl/multicycle_alu.sv
// Arithmetic/logic stage of the 8-bit CPU datapath: single-cycle logic/add ops and a
// WIDTH-cycle unsigned shift-add multiply, with a Start/Busy/Done handshake.
module multicycle_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] ABus,
  input  logic [WIDTH-1:0] BBus,
  input  logic [2:0]       OpCode,
  input  logic             Start,
  output logic [WIDTH-1:0] CBus,
  output logic [WIDTH-1:0] CBusHigh,
  output logic             Busy,
  output logic             Done,
  output logic             CarryFlag,
  output logic             ZeroFlag
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StExec, StMult} state_e;

  state_e             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CntW-1:0]    count_q;

  // Bit WIDTH of alu_res carries the carry/borrow/shift-out flag.
  logic [WIDTH:0]     alu_res;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] mul_sum;

  always_comb begin
    alu_res = '0;
    case (op_q)
      3'b000:  alu_res = {1'b0, a_q} + {1'b0, b_q};
      3'b001:  alu_res = {1'b0, a_q} - {1'b0, b_q};
      3'b010:  alu_res = {1'b0, a_q & b_q};
      3'b011:  alu_res = {1'b0, a_q | b_q};
      3'b100:  alu_res = {1'b0, a_q ^ b_q};
      3'b101:  alu_res = {a_q[WIDTH-1], a_q[WIDTH-2:0], 1'b0};
      3'b110:  alu_res = {a_q[0], 1'b0, a_q[WIDTH-1:1]};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    partial = '0;
    if (b_q[count_q]) begin
      partial = {{WIDTH{1'b0}}, a_q} << count_q;
    end
    mul_sum = acc_q + partial;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      CBus      <= '0;
      CBusHigh  <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      CarryFlag <= 1'b0;
      ZeroFlag  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        StIdle: begin
          if (Start) begin
            a_q     <= ABus;
            b_q     <= BBus;
            op_q    <= OpCode;
            acc_q   <= '0;
            count_q <= '0;
            Busy    <= 1'b1;
            state   <= (OpCode == 3'b111) ? StMult : StExec;
          end
        end
        StExec: begin
          CBus      <= alu_res[WIDTH-1:0];
          CBusHigh  <= '0;
          CarryFlag <= alu_res[WIDTH];
          ZeroFlag  <= (alu_res[WIDTH-1:0] == '0);
          Done      <= 1'b1;
          Busy      <= 1'b0;
          state     <= StIdle;
        end
        StMult: begin
          acc_q   <= mul_sum;
          count_q <= count_q + 1'b1;
          // Outputs only change on the final iteration; intermediate sums stay internal.
          if (count_q == LastCnt) begin
            CBus      <= mul_sum[WIDTH-1:0];
            CBusHigh  <= mul_sum[2*WIDTH-1:WIDTH];
            CarryFlag <= |mul_sum[2*WIDTH-1:WIDTH];
            ZeroFlag  <= (mul_sum == '0);
            Done      <= 1'b1;
            Busy      <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
